// File: rtl/weight_stream_packer.sv
// weight_stream_packer: serializes one 5x5 weight filter into 32-bit valid/ready words in weight-store order.
// Define WEIGHT_STREAM_PACKER_WORD_IDX_EN to add the TX_WORD_IDX output.
module weight_stream_packer #(
    parameter int INPUT_WIDTH  = 32,
    parameter int BUFFER_WIDTH = 40
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    LOAD,
    input  logic [BUFFER_WIDTH-1:0] ROW_0,
    input  logic [BUFFER_WIDTH-1:0] ROW_1,
    input  logic [BUFFER_WIDTH-1:0] ROW_2,
    input  logic [BUFFER_WIDTH-1:0] ROW_3,
    input  logic [BUFFER_WIDTH-1:0] ROW_4,
    input  logic [3:0]              PARAM_R,
    input  logic [3:0]              PARAM_S,
    output logic [INPUT_WIDTH-1:0]  TX_DATA,
    output logic                    TX_VALID,
    input  logic                    TX_READY,
    output logic                    TX_LAST,
    output logic                    BUSY,
    output logic                    DONE
`ifdef WEIGHT_STREAM_PACKER_WORD_IDX_EN
    ,
    output logic [2:0]              TX_WORD_IDX
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
    state_t                        state_q;
    logic [BUFFER_WIDTH-1:0]       rows_q [5];
    logic [2:0]                    idx_q, last_q, last_d;
    logic                          full_q, done_q;
    logic [6:0][INPUT_WIDTH-1:0]   full_w;
    logic [INPUT_WIDTH-1:0]        row_w;
    // Full mode packs the 200 weight bits back to back; the tail of the last word is zero.
    assign full_w = {rows_q[0], rows_q[1], rows_q[2], rows_q[3], rows_q[4],
                     {(7*INPUT_WIDTH-5*BUFFER_WIDTH){1'b0}}};
    assign row_w  = rows_q[idx_q > 3'd4 ? 3'd4 : idx_q][BUFFER_WIDTH-1 -: INPUT_WIDTH];
    assign last_d = PARAM_S >= 4'd5 ? 3'd6 :
                    PARAM_R == 4'd0 ? 3'd0 :
                    PARAM_R >= 4'd5 ? 3'd4 : 3'(PARAM_R - 4'd1);
    assign TX_VALID = state_q == SEND;
    assign BUSY     = TX_VALID;
    assign TX_DATA  = !TX_VALID ? '0 : full_q ? full_w[3'd6 - idx_q] : row_w;
    assign TX_LAST  = TX_VALID && idx_q == last_q;
    assign DONE     = done_q;
`ifdef WEIGHT_STREAM_PACKER_WORD_IDX_EN
    assign TX_WORD_IDX = idx_q;
`endif
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= IDLE;
            rows_q  <= '{default: '0};
            idx_q   <= '0;
            last_q  <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (LOAD) begin
                    rows_q  <= '{ROW_0, ROW_1, ROW_2, ROW_3, ROW_4};
                    last_q  <= last_d;
                    full_q  <= PARAM_S >= 4'd5;
                    idx_q   <= '0;
                    state_q <= SEND;
                end
                SEND: if (TX_READY) begin
                    idx_q  <= TX_LAST ? 3'd0 : idx_q + 3'd1;
                    done_q <= TX_LAST;
                    if (TX_LAST) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
